fir_band_scheduler: RTL and testbench

FIR_BAND_SCHEDULER -- requirements
Module: fir_band_scheduler

---
 rtl/fir_band_scheduler.sv | 161 ++++++++++++++++
 tb/tb_fir_band_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_band_scheduler.sv
// Round-robin scheduler sharing one FIR engine among NBANDS band requesters.
// One service is IDLE -> ISSUE -> WAIT -> DELIVER; a lost engine-done in WAIT
// raises a sticky error and abandons the service without delivering.
module fir_band_scheduler #(
   parameter int NBANDS  = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk_slow,
   input  logic                   rst,
   input  logic [NBANDS-1:0]      band_req,
   input  logic [16*NBANDS-1:0]   band_din,
   output logic [NBANDS-1:0]      band_gnt,
   output logic                   eng_start,
   output logic [15:0]            eng_din,
   output logic [$clog2(NBANDS)-1:0] eng_bank,
   input  logic                   eng_done,
   input  logic [15:0]            eng_dout,
   output logic [15:0]            band_dout,
   output logic [NBANDS-1:0]      band_valid,
   output logic                   busy,
   output logic                   err
);

   localparam int BW = $clog2(NBANDS);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_DELIVER = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [BW-1:0]       rr_q, rr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [15:0]         eng_din_q, eng_din_d;
   logic [BW-1:0]       bank_q, bank_d;
   logic [15:0]         dout_q, dout_d;
   logic [NBANDS-1:0]   gnt_q, gnt_d;
   logic [NBANDS-1:0]   valid_q, valid_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                win_found_s;
   logic [BW-1:0]       win_idx_s;
   logic [BW-1:0]       cand_s;

   function automatic logic [NBANDS-1:0] onehot(input logic [BW-1:0] idx);
      onehot = {{(NBANDS-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Pick the first requesting band at or after the round-robin pointer.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int i = NBANDS - 1; i >= 0; i--) begin
         cand_s = rr_q + BW'(i);
         if (band_req[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Next-state and next-output logic of the service FSM.
   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      eng_din_d = eng_din_q;
      bank_d    = bank_q;
      dout_d    = dout_q;
      gnt_d     = '0;
      valid_d   = '0;
      start_d   = 1'b0;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (win_found_s) begin
               eng_din_d = band_din[{win_idx_s, 4'b0000} +: 16];
               bank_d    = win_idx_s;
               gnt_d     = onehot(win_idx_s);
               start_d   = 1'b1;
               state_d   = S_ISSUE;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_ISSUE: begin
            // eng_done here is concurrent with start and cannot be ours.
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (eng_done) begin
               dout_d  = eng_dout;
               valid_d = onehot(bank_q);
               state_d = S_DELIVER;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               rr_d    = bank_q + BW'(1);
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         S_DELIVER: begin
            rr_d    = bank_q + BW'(1);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; reset aborts any service in flight.
   always_ff @(posedge clk_slow or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         rr_q      <= '0;
         cnt_q     <= '0;
         eng_din_q <= 16'h0000;
         bank_q    <= '0;
         dout_q    <= 16'h0000;
         gnt_q     <= '0;
         valid_q   <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         cnt_q     <= cnt_d;
         eng_din_q <= eng_din_d;
         bank_q    <= bank_d;
         dout_q    <= dout_d;
         gnt_q     <= gnt_d;
         valid_q   <= valid_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign band_gnt   = gnt_q;
   assign eng_start  = start_q;
   assign eng_din    = eng_din_q;
   assign eng_bank   = bank_q;
   assign band_dout  = dout_q;
   assign band_valid = valid_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Scoreboard bench for fir_band_scheduler: directed services push expected
// grants/deliveries into queues, a monitor pops and compares them.
module tb_fir_band_scheduler;

   logic        clk_slow;
   logic        rst;
   logic [3:0]  band_req;
   logic [63:0] band_din;
   logic [3:0]  band_gnt;
   logic        eng_start;
   logic [15:0] eng_din;
   logic [1:0]  eng_bank;
   logic        eng_done;
   logic [15:0] eng_dout;
   logic [15:0] band_dout;
   logic [3:0]  band_valid;
   logic        busy;
   logic        err;

   logic        resp_done;
   logic        spur;
   int          eng_delay;
   logic        resp_mode;
   logic [15:0] resp_val;

   int checks;
   int errors;
   int cyc;

   typedef struct {
      logic [3:0]  gnt;
      logic [1:0]  bank;
      logic [15:0] din;
      int          gap;
   } gnt_exp_t;

   typedef struct {
      logic [3:0]  v;
      logic [15:0] dout;
      logic [1:0]  bank;
      logic [15:0] din;
   } val_exp_t;

   gnt_exp_t gq[$];
   val_exp_t vq[$];

   assign eng_done = resp_done | spur;

   fir_band_scheduler #(.NBANDS(4), .TIMEOUT(64)) dut (
      .clk_slow   (clk_slow),
      .rst        (rst),
      .band_req   (band_req),
      .band_din   (band_din),
      .band_gnt   (band_gnt),
      .eng_start  (eng_start),
      .eng_din    (eng_din),
      .eng_bank   (eng_bank),
      .eng_done   (eng_done),
      .eng_dout   (eng_dout),
      .band_dout  (band_dout),
      .band_valid (band_valid),
      .busy       (busy),
      .err        (err)
   );

   initial begin
      clk_slow = 1'b0;
      forever #5 clk_slow = ~clk_slow;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_g(input logic [3:0] g, input logic [1:0] b, input logic [15:0] d, input int gap);
      gnt_exp_t e;
      e.gnt = g; e.bank = b; e.din = d; e.gap = gap;
      gq.push_back(e);
   endtask

   task automatic push_v(input logic [3:0] v, input logic [15:0] o, input logic [1:0] b, input logic [15:0] d);
      val_exp_t e;
      e.v = v; e.dout = o; e.bank = b; e.din = d;
      vq.push_back(e);
   endtask

   // Engine model: answers eng_start after eng_delay cycles (0 = never).
   initial begin
      int d;
      resp_done = 1'b0;
      eng_dout  = 16'h0000;
      forever begin
         @(negedge clk_slow);
         if (eng_start && rst && eng_delay > 0) begin
            d = eng_delay;
            repeat (d) @(negedge clk_slow);
            resp_done = 1'b1;
            eng_dout  = resp_mode ? resp_val : ~eng_din;
            @(negedge clk_slow);
            resp_done = 1'b0;
            eng_dout  = 16'h0000;
         end
      end
   end

   // Monitor: compares every grant and delivery against the scoreboard.
   initial begin
      gnt_exp_t ge;
      val_exp_t ve;
      logic [3:0] prev_g, prev_v;
      logic       prev_s;
      int         last_g;
      prev_g = 4'h0; prev_v = 4'h0; prev_s = 1'b0; last_g = 0; cyc = 0;
      forever begin
         @(negedge clk_slow);
         cyc++;
         if (!rst) begin
            prev_g = 4'h0; prev_v = 4'h0; prev_s = 1'b0;
         end else begin
            if (band_gnt != 4'h0) begin
               chk("gnt_not_back_to_back", {28'h0, prev_g}, 32'h0);
               if (gq.size() == 0) begin
                  chk("unexpected_gnt", {28'h0, band_gnt}, 32'h0);
               end else begin
                  ge = gq.pop_front();
                  chk("gnt", {28'h0, band_gnt}, {28'h0, ge.gnt});
                  chk("gnt_bank", {30'h0, eng_bank}, {30'h0, ge.bank});
                  chk("gnt_din", {16'h0, eng_din}, {16'h0, ge.din});
                  chk("gnt_start", {31'h0, eng_start}, 32'h1);
                  if (ge.gap >= 0) chk("gnt_period", cyc - last_g, ge.gap);
               end
               last_g = cyc;
            end
            if (eng_start) chk("start_not_back_to_back", {31'h0, prev_s}, 32'h0);
            if (band_valid != 4'h0) begin
               chk("valid_not_back_to_back", {28'h0, prev_v}, 32'h0);
               if (vq.size() == 0) begin
                  chk("unexpected_valid", {28'h0, band_valid}, 32'h0);
               end else begin
                  ve = vq.pop_front();
                  chk("valid", {28'h0, band_valid}, {28'h0, ve.v});
                  chk("valid_dout", {16'h0, band_dout}, {16'h0, ve.dout});
                  chk("valid_bank", {30'h0, eng_bank}, {30'h0, ve.bank});
                  chk("valid_din_held", {16'h0, eng_din}, {16'h0, ve.din});
               end
            end
            prev_g = band_gnt; prev_v = band_valid; prev_s = eng_start;
         end
      end
   end

   task automatic wait_gnt();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk_slow);
         if (band_gnt != 4'h0) return;
      end
      chk("wait_gnt_timeout", 32'h0, 32'h1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk_slow);
         if (gq.size() == 0 && vq.size() == 0 && !busy) return;
      end
      chk("drain_timeout", gq.size() + vq.size(), 32'h0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},   {28'h0, band_gnt},   32'h0);
      chk({tag, "_valid"}, {28'h0, band_valid}, 32'h0);
      chk({tag, "_start"}, {31'h0, eng_start},  32'h0);
      chk({tag, "_busy"},  {31'h0, busy},       32'h0);
      chk({tag, "_err"},   {31'h0, err},        32'h0);
      chk({tag, "_din"},   {16'h0, eng_din},    32'h0);
      chk({tag, "_bank"},  {30'h0, eng_bank},   32'h0);
      chk({tag, "_dout"},  {16'h0, band_dout},  32'h0);
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; band_req = 4'h0; band_din = 64'h0;
      spur = 1'b0; eng_delay = 0; resp_mode = 1'b0; resp_val = 16'h0000;
      repeat (3) @(negedge clk_slow);
      chk_all_zero("reset");
      rst = 1'b1;

      // All four bands requesting, engine done one cycle after start.
      band_din  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
      eng_delay = 1; resp_mode = 1'b0;
      push_g(4'b0001, 2'd0, 16'h1000, -1); push_v(4'b0001, 16'hEFFF, 2'd0, 16'h1000);
      push_g(4'b0010, 2'd1, 16'h1001, 4);  push_v(4'b0010, 16'hEFFE, 2'd1, 16'h1001);
      push_g(4'b0100, 2'd2, 16'h1002, 4);  push_v(4'b0100, 16'hEFFD, 2'd2, 16'h1002);
      push_g(4'b1000, 2'd3, 16'h1003, 4);  push_v(4'b1000, 16'hEFFC, 2'd3, 16'h1003);
      push_g(4'b0001, 2'd0, 16'h1000, 4);  push_v(4'b0001, 16'hEFFF, 2'd0, 16'h1000);
      band_req = 4'hF;
      for (int n = 0; n < 5; n++) wait_gnt();
      band_req = 4'h0;
      drain();

      // Single request on band 2; its band_din changes after the grant.
      band_din  = {16'h7777, 16'h1234, 16'h5555, 16'h6666};
      eng_delay = 3; resp_mode = 1'b1; resp_val = 16'hABCD;
      push_g(4'b0100, 2'd2, 16'h1234, -1); push_v(4'b0100, 16'hABCD, 2'd2, 16'h1234);
      band_req = 4'b0100;
      wait_gnt();
      band_req = 4'h0; band_din[47:32] = 16'hDEAD;
      drain();

      // Spurious done in IDLE, then in ISSUE; pointer at 3 selects band 3.
      band_din = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      spur = 1'b1; @(negedge clk_slow); spur = 1'b0;
      repeat (2) @(negedge clk_slow);
      chk("spur_idle_busy", {31'h0, busy}, 32'h0);
      eng_delay = 2; resp_val = 16'h5A5A;
      push_g(4'b1000, 2'd3, 16'h3333, -1); push_v(4'b1000, 16'h5A5A, 2'd3, 16'h3333);
      band_req = 4'b1001;
      wait_gnt();
      band_req = 4'h0; spur = 1'b1;
      @(negedge clk_slow); spur = 1'b0;
      drain();

      // Done arrives in the last WAIT cycle: delivery wins over timeout.
      band_din[31:16] = 16'hB1B1;
      eng_delay = 64; resp_val = 16'hC0DE;
      push_g(4'b0010, 2'd1, 16'hB1B1, -1); push_v(4'b0010, 16'hC0DE, 2'd1, 16'hB1B1);
      band_req = 4'b0010;
      wait_gnt();
      band_req = 4'h0;
      drain();
      chk("late_done_err", {31'h0, err}, 32'h0);

      // Timeout on band 1; next grant must go to band 2.
      eng_delay = 0;
      push_g(4'b0010, 2'd1, 16'hB1B1, -1);
      band_req = 4'b0010;
      wait_gnt();
      band_req = 4'h0;
      repeat (64) @(negedge clk_slow);
      chk("to_err_before", {31'h0, err}, 32'h0);
      chk("to_busy_before", {31'h0, busy}, 32'h1);
      @(negedge clk_slow);
      chk("to_err_after", {31'h0, err}, 32'h1);
      chk("to_busy_after", {31'h0, busy}, 32'h0);
      eng_delay = 1; resp_mode = 1'b0;
      push_g(4'b0100, 2'd2, 16'h2222, -1); push_v(4'b0100, 16'hDDDD, 2'd2, 16'h2222);
      band_req = 4'b0110;
      wait_gnt();
      band_req = 4'h0;
      drain();
      chk("err_sticky", {31'h0, err}, 32'h1);

      // Reset during WAIT of band 3, then 1001 must grant band 0.
      eng_delay = 0;
      push_g(4'b1000, 2'd3, 16'h3333, -1);
      band_req = 4'b1000;
      wait_gnt();
      band_req = 4'h0;
      repeat (5) @(negedge clk_slow);
      rst = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk_slow);
      rst = 1'b1;
      band_din[15:0] = 16'h0F0F; eng_delay = 1; resp_mode = 1'b0;
      push_g(4'b0001, 2'd0, 16'h0F0F, -1); push_v(4'b0001, 16'hF0F0, 2'd0, 16'h0F0F);
      band_req = 4'b1001;
      wait_gnt();
      band_req = 4'h0;
      drain();
      chk("queues_empty", gq.size() + vq.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
